// File: rtl/fmap_pingpong_buf.sv
// fmap_pingpong_buf: two-bank CH x H x W feature-map buffer, one writer and a dual-port reader.
// Define FMAP_RELU_EN to store negative activations as zero (fused ReLU).
module fmap_pingpong_buf #(
  parameter int DW = 8,
  parameter int CH = 8,
  parameter int H = 28,
  parameter int W = 28,
  parameter int AW = $clog2(H * W),
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CW-1:0]        wr_ch,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 wr_last,
  output logic                 wr_ready,
  input  logic                 rd_en,
  input  logic [CW-1:0]        rd_ch,
  input  logic [AW-1:0]        rd_addr1,
  input  logic [AW-1:0]        rd_addr2,
  output logic signed [DW-1:0] rd_data1,
  output logic signed [DW-1:0] rd_data2,
  output logic                 rd_valid,
  output logic                 rd_ready,
  input  logic                 rd_release,
  input  logic                 err_clr,
  output logic [2:0]           err,
  output logic                 wr_bank,
  output logic                 rd_bank
);
  localparam int N = H * W;
  localparam int D = 2 * CH * N;
  localparam int IW = $clog2(D);
  logic signed [DW-1:0] mem [D];
  logic [1:0] full;
  logic wr_sel, rd_sel, wr_in, rd_in1, rd_in2, wr_do, rd_do;
  logic [IW-1:0] wr_idx, rd_idx1, rd_idx2;
  logic signed [DW-1:0] wr_val;
  logic [2:0] err_new;
  assign wr_ready = !full[wr_sel];
  assign rd_ready = full[rd_sel];
  assign wr_bank = wr_sel;
  assign rd_bank = rd_sel;
  always_comb begin
    wr_in = (32'(wr_ch) < CH) && (32'(wr_addr) < N);
    rd_in1 = (32'(rd_ch) < CH) && (32'(rd_addr1) < N);
    rd_in2 = (32'(rd_ch) < CH) && (32'(rd_addr2) < N);
    wr_do = wr_en && wr_ready && wr_in;
    rd_do = rd_en && rd_ready;
    wr_idx = IW'(32'(wr_sel) * CH * N + 32'(wr_ch) * N + 32'(wr_addr));
    rd_idx1 = IW'(32'(rd_sel) * CH * N + 32'(rd_ch) * N + 32'(rd_addr1));
    rd_idx2 = IW'(32'(rd_sel) * CH * N + 32'(rd_ch) * N + 32'(rd_addr2));
`ifdef FMAP_RELU_EN
    wr_val = wr_data[DW-1] ? '0 : wr_data;
`else
    wr_val = wr_data;
`endif
    err_new = {(rd_do && !(rd_in1 && rd_in2)) || (wr_en && wr_ready && !wr_in),
               (rd_en || rd_release) && !rd_ready,
               (wr_en || wr_last) && !wr_ready};
  end
  always_ff @(posedge clk)
    if (wr_do) mem[wr_idx] <= wr_val;
  // Commit and release never hit the same bank: one needs it empty, the other full.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      rd_valid <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
      err <= '0;
    end else begin
      if (wr_last && wr_ready) begin
        full[wr_sel] <= 1'b1;
        wr_sel <= !wr_sel;
      end
      if (rd_release && rd_ready) begin
        full[rd_sel] <= 1'b0;
        rd_sel <= !rd_sel;
      end
      rd_valid <= rd_do;
      if (rd_do) begin
        rd_data1 <= rd_in1 ? mem[rd_idx1] : '0;
        rd_data2 <= rd_in2 ? mem[rd_idx2] : '0;
      end
      err <= (err_clr ? 3'b000 : err) | err_new;
    end
endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// tb_fmap_pingpong_buf: directed table, ping-pong/corner sequences and random traffic against an array model.
// Non-power-of-two CH and H*W so that out-of-range channel/pixel indices are encodable on the ports.
module tb_fmap_pingpong_buf;
  localparam int DW = 8, CH = 3, H = 3, W = 5, N = H * W, AW = 4, CW = 2;
`ifdef FMAP_RELU_EN
  localparam int N3 = 0;
`else
  localparam int N3 = -3;
`endif
  logic clk, rst, wr_en, wr_last, wr_ready, rd_en, rd_valid, rd_ready, rd_release, err_clr, wr_bank, rd_bank;
  logic [CW-1:0] wr_ch, rd_ch;
  logic [AW-1:0] wr_addr, rd_addr1, rd_addr2;
  logic signed [DW-1:0] wr_data, rd_data1, rd_data2;
  logic [2:0] err;
  int n_chk = 0, n_pass = 0;

  fmap_pingpong_buf #(.DW(DW), .CH(CH), .H(H), .W(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_release(rd_release), .err_clr(err_clr), .err(err),
    .wr_bank(wr_bank), .rd_bank(rd_bank));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic we, wl, re, rr, ec;
    logic [CW-1:0] wc, rc;
    logic [AW-1:0] wa, a1, a2;
    logic [DW-1:0] wd;
  } in_t;
  typedef struct {
    in_t v;
    logic rv;
    logic signed [31:0] d1, d2;
    logic [2:0] e;
    logic wr, rr, wb, rb;
  } tv_t;

  // Model: plain per-bank/channel/pixel array, bank full flags and selectors.
  logic signed [31:0] mm [2][CH][N];
  bit [1:0] fm;
  bit ws, rs, rvm;
  logic [2:0] em;
  logic signed [31:0] d1m, d2m;

  function automatic in_t iv(input bit we, wl, re, rr, ec, input int wc, wa, wd, rc, a1, a2);
    in_t v;
    v.we = we; v.wl = wl; v.re = re; v.rr = rr; v.ec = ec;
    v.wc = CW'(wc); v.wa = AW'(wa); v.wd = DW'(wd);
    v.rc = CW'(rc); v.a1 = AW'(a1); v.a2 = AW'(a2);
    return v;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    if ($isunknown(exp)) return;
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    fm = 2'b00; ws = 0; rs = 0; rvm = 0; em = 3'b000; d1m = 0; d2m = 0;
  endtask

  task automatic model_step(input in_t v);
    bit wrdy, rrdy, ok1, ok2;
    logic [2:0] ne;
    int c, a, x;
    wrdy = !fm[ws]; rrdy = fm[rs]; ne = 3'b000; rvm = 0;
    ne[0] = (v.we || v.wl) && !wrdy;
    ne[1] = (v.re || v.rr) && !rrdy;
    if (v.we && wrdy) begin
      c = int'(v.wc); a = int'(v.wa); x = $signed(v.wd);
`ifdef FMAP_RELU_EN
      if (x < 0) x = 0;
`endif
      if (c < CH && a < N) mm[ws][c][a] = x;
      else ne[2] = 1;
    end
    if (v.re && rrdy) begin
      c = int'(v.rc);
      ok1 = c < CH && int'(v.a1) < N;
      ok2 = c < CH && int'(v.a2) < N;
      d1m = ok1 ? mm[rs][c][int'(v.a1)] : 0;
      d2m = ok2 ? mm[rs][c][int'(v.a2)] : 0;
      rvm = 1;
      if (!ok1 || !ok2) ne[2] = 1;
    end
    if (v.wl && wrdy) begin fm[ws] = 1; ws = !ws; end
    if (v.rr && rrdy) begin fm[rs] = 0; rs = !rs; end
    em = (v.ec ? 3'b000 : em) | ne;
  endtask

  task automatic check_all();
    chk("wr_ready", wr_ready, !fm[ws]);
    chk("rd_ready", rd_ready, fm[rs]);
    chk("rd_valid", rd_valid, rvm);
    chk("rd_data1", rd_data1, d1m);
    chk("rd_data2", rd_data2, d2m);
    chk("err", err, em);
    chk("wr_bank", wr_bank, ws);
    chk("rd_bank", rd_bank, rs);
  endtask

  task automatic drive(input in_t v);
    wr_en = v.we; wr_last = v.wl; rd_en = v.re; rd_release = v.rr; err_clr = v.ec;
    wr_ch = v.wc; wr_addr = v.wa; wr_data = v.wd; rd_ch = v.rc; rd_addr1 = v.a1; rd_addr2 = v.a2;
  endtask

  task automatic cyc(input in_t v);
    drive(v);
    @(posedge clk);
    model_step(v);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    drive(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 0;
    #1 check_all();
  endtask

  tv_t tv [10];

  initial begin
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < CH; c++)
        for (int a = 0; a < N; a++) mm[b][c][a] = 32'bx;
    tv[0] = '{iv(1, 0, 0, 0, 0, 1, 5, -3, 0, 0, 0), 0, 0, 0, 3'b000, 1, 0, 0, 0};
    tv[1] = '{iv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 3'b000, 1, 1, 1, 0};
    tv[2] = '{iv(0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0), 1, N3, 32'bx, 3'b000, 1, 1, 1, 0};
    tv[3] = '{iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, N3, 32'bx, 3'b000, 1, 1, 1, 0};
    tv[4] = '{iv(0, 0, 1, 0, 0, 0, 0, 0, 3, 5, 0), 1, 0, 0, 3'b100, 1, 1, 1, 0};
    tv[5] = '{iv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 3'b000, 1, 1, 1, 0};
    tv[6] = '{iv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 3'b000, 1, 0, 1, 1};
    tv[7] = '{iv(0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0), 0, 0, 0, 3'b010, 1, 0, 1, 1};
    tv[8] = '{iv(0, 0, 1, 0, 1, 0, 0, 0, 1, 5, 0), 0, 0, 0, 3'b010, 1, 0, 1, 1};
    tv[9] = '{iv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 3'b000, 1, 0, 1, 1};
    rst = 1;
    do_reset();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].v);
      chk($sformatf("tv%0d_rd_valid", i), rd_valid, tv[i].rv);
      chk($sformatf("tv%0d_rd_data1", i), rd_data1, tv[i].d1);
      chk($sformatf("tv%0d_rd_data2", i), rd_data2, tv[i].d2);
      chk($sformatf("tv%0d_err", i), err, tv[i].e);
      chk($sformatf("tv%0d_wr_ready", i), wr_ready, tv[i].wr);
      chk($sformatf("tv%0d_rd_ready", i), rd_ready, tv[i].rr);
      chk($sformatf("tv%0d_wr_bank", i), wr_bank, tv[i].wb);
      chk($sformatf("tv%0d_rd_bank", i), rd_bank, tv[i].rb);
    end
    // Ping-pong: fill bank0, then fill bank1 while reading bank0.
    do_reset();
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < N; a++) cyc(iv(1, 0, 0, 0, 0, c, a, 'h11, 0, 0, 0));
    cyc(iv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("pp_wr_bank", wr_bank, 1);
    chk("pp_rd_ready", rd_ready, 1);
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < N; a++) begin
        cyc(iv(1, 0, 1, 0, 0, c, a, 'h22, $urandom_range(0, CH - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1)));
        chk("pp_read_old", rd_data1, 'h11);
      end
    cyc(iv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("pp_both_full_wr_ready", wr_ready, 0);
    cyc(iv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("pp_rel_rd_bank", rd_bank, 1);
    chk("pp_rel_wr_ready", wr_ready, 1);
    cyc(iv(0, 0, 1, 0, 0, 0, 0, 0, 1, 3, 7));
    chk("pp_read_new1", rd_data1, 'h22);
    chk("pp_read_new2", rd_data2, 'h22);
    // Overflow with both banks full.
    cyc(iv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(iv(1, 1, 0, 0, 0, 0, 0, 99, 0, 0, 0));
    chk("ovf_err", err, 3'b001);
    chk("ovf_wr_bank", wr_bank, 1);
    cyc(iv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(iv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc(iv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("ovf_no_write", rd_data1, 'h11);
    // Commit and release together with exactly one bank full.
    cyc(iv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("sim_wr_bank", wr_bank, 0);
    chk("sim_rd_bank", rd_bank, 1);
    chk("sim_err", err, 3'b000);
    chk("sim_rd_ready", rd_ready, 1);
    cyc(iv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("sim_read", rd_data1, 'h22);
    // Out-of-range writes.
    cyc(iv(1, 0, 0, 0, 0, 3, 0, 5, 0, 0, 0));
    chk("rng_ch_err", err, 3'b100);
    cyc(iv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("rng_clr", err, 3'b000);
    cyc(iv(1, 0, 0, 0, 0, 0, 15, 'h55, 0, 0, 0));
    chk("rng_addr_err", err, 3'b100);
    cyc(iv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("rng_clr2", err, 3'b000);
    // Random traffic, including out-of-range indices.
    for (int i = 0; i < 1500; i++)
      cyc(iv($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6,
             $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, CH),
             $urandom_range(0, N), $urandom_range(0, 255), $urandom_range(0, CH),
             $urandom_range(0, N), $urandom_range(0, N)));
    // Asynchronous reset in the middle of a fill, with a read result and an error pending.
    do_reset();
    cyc(iv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) cyc(iv(1, 0, i == 6, 0, 0, i == 2 ? 3 : 0, i, i + 1, 0, 1, 2));
    chk("mid_rd_valid_pre", rd_valid, 1);
    chk("mid_err_pre", err, 3'b100);
    #2 rst = 1;
    #1;
    model_reset();
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_rd_data1", rd_data1, 0);
    chk("mid_rd_data2", rd_data2, 0);
    chk("mid_wr_ready", wr_ready, 1);
    chk("mid_rd_ready", rd_ready, 0);
    chk("mid_err", err, 3'b000);
    #3 rst = 0;
    cyc(iv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("post_rst_rd_valid", rd_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
